alu_arbiter: RTL and testbench

Shares one 32-bit ALU instance (4-bit opcode, Out/Zero) between two requesters, e.g. the execute stage (port 0) and a multi-cycle helper unit (port 1).
- Round-robin arbitration with per-port valid/ready request handshakes.
- One registered result slot, returned to the granted requester over its own valid/ready response handshake.
- Illegal opcodes are flagged rather than passed through to the ALU.

---
 rtl/alu_arbiter_if.sv | 39 +++
 rtl/alu_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_alu_arbiter.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_arbiter.
// Port-0 and port-1 handshakes share one interface; the result fields are common to both.
interface alu_arbiter_if;
  logic        req_valid_0;
  logic        req_ready_0;
  logic [31:0] req_a_0;
  logic [31:0] req_b_0;
  logic [3:0]  req_op_0;

  logic        req_valid_1;
  logic        req_ready_1;
  logic [31:0] req_a_1;
  logic [31:0] req_b_1;
  logic [3:0]  req_op_1;

  logic        resp_valid_0;
  logic        resp_ready_0;
  logic        resp_valid_1;
  logic        resp_ready_1;
  logic [31:0] resp_data;
  logic        resp_zero;
  logic        resp_err;

  modport master (
    output req_valid_0, req_a_0, req_b_0, req_op_0,
    output req_valid_1, req_a_1, req_b_1, req_op_1,
    output resp_ready_0, resp_ready_1,
    input  req_ready_0, req_ready_1,
    input  resp_valid_0, resp_valid_1, resp_data, resp_zero, resp_err
  );

  modport slave (
    input  req_valid_0, req_a_0, req_b_0, req_op_0,
    input  req_valid_1, req_a_1, req_b_1, req_op_1,
    input  resp_ready_0, resp_ready_1,
    output req_ready_0, req_ready_1,
    output resp_valid_0, resp_valid_1, resp_data, resp_zero, resp_err
  );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one 32-bit ALU between two requesters, with one registered
// result slot. Per-port grant counters are built only when ALU_ARB_STATS_EN is defined.
module alu_arbiter
`ifdef ALU_ARB_STATS_EN
  #(parameter int CNT_W = 16)
`endif
(
  input  logic clk,
  input  logic reset_n,
  alu_arbiter_if.slave bus
`ifdef ALU_ARB_STATS_EN
  ,
  output logic [CNT_W-1:0] grant_cnt_0,
  output logic [CNT_W-1:0] grant_cnt_1
`endif
);

  typedef enum logic [1:0] {
    SLOT_EMPTY  = 2'd0,
    SLOT_FULL_0 = 2'd1,
    SLOT_FULL_1 = 2'd2
  } slot_state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SRL  = 4'd4,
    OP_SRA  = 4'd5,
    OP_SLL  = 4'd6,
    OP_SLT  = 4'd7,
    OP_SLTU = 4'd8
  } alu_op_e;

  slot_state_e state_q, state_d;
  logic        ptr_q, ptr_d;
  logic [31:0] data_q, data_d;
  logic        zero_q, zero_d;
  logic        err_q, err_d;

  logic        slot_free;
  logic        grant_0;
  logic        grant_1;
  logic        grant_any;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_op;
  logic [31:0] alu_out;
  logic        op_illegal;
  logic [4:0]  shamt;
  logic        shift_big;

  // The slot may be refilled in the same cycle its current owner drains it.
  always_comb begin
    slot_free = 1'b0;
    case (state_q)
      SLOT_EMPTY:  slot_free = 1'b1;
      SLOT_FULL_0: slot_free = bus.resp_ready_0;
      SLOT_FULL_1: slot_free = bus.resp_ready_1;
      default:     slot_free = 1'b0;
    endcase
  end

  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (slot_free) begin
      if (bus.req_valid_0 && bus.req_valid_1) begin
        grant_0 = ~ptr_q;
        grant_1 = ptr_q;
      end else begin
        grant_0 = bus.req_valid_0;
        grant_1 = bus.req_valid_1;
      end
    end
    grant_any = grant_0 | grant_1;
  end

  assign bus.req_ready_0 = grant_0;
  assign bus.req_ready_1 = grant_1;

  always_comb begin
    alu_a  = bus.req_a_0;
    alu_b  = bus.req_b_0;
    alu_op = bus.req_op_0;
    if (grant_1) begin
      alu_a  = bus.req_a_1;
      alu_b  = bus.req_b_1;
      alu_op = bus.req_op_1;
    end
  end

  assign op_illegal = (alu_op > 4'd8);
  assign shamt      = alu_b[4:0];
  // Any set bit above bit 4 means a shift of 32 or more, which empties the word.
  assign shift_big  = |alu_b[31:5];

  always_comb begin
    alu_out = 32'd0;
    case (alu_op)
      OP_ADD:  alu_out = alu_a + alu_b;
      OP_SUB:  alu_out = alu_a - alu_b;
      OP_AND:  alu_out = alu_a & alu_b;
      OP_OR:   alu_out = alu_a | alu_b;
      OP_SRL:  alu_out = shift_big ? 32'd0 : (alu_a >> shamt);
      OP_SRA:  alu_out = shift_big ? {32{alu_a[31]}}
                                   : $unsigned($signed(alu_a) >>> shamt);
      OP_SLL:  alu_out = shift_big ? 32'd0 : (alu_a << shamt);
      OP_SLT:  alu_out = {31'd0, ($signed(alu_a) < $signed(alu_b))};
      OP_SLTU: alu_out = {31'd0, (alu_a < alu_b)};
      default: alu_out = 32'd0;
    endcase
  end

  // Result fields only change on a grant, so they hold their last values once drained.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    zero_d  = zero_q;
    err_d   = err_q;

    if (grant_any) begin
      state_d = grant_0 ? SLOT_FULL_0 : SLOT_FULL_1;
      ptr_d   = grant_0;
      err_d   = op_illegal;
      if (op_illegal) begin
        data_d = 32'd0;
        zero_d = 1'b1;
      end else begin
        data_d = alu_out;
        zero_d = (alu_out == 32'd0);
      end
    end else if (slot_free) begin
      state_d = SLOT_EMPTY;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= SLOT_EMPTY;
      ptr_q   <= 1'b0;
      data_q  <= 32'd0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
    end
  end

  assign bus.resp_valid_0 = (state_q == SLOT_FULL_0);
  assign bus.resp_valid_1 = (state_q == SLOT_FULL_1);
  assign bus.resp_data    = data_q;
  assign bus.resp_zero    = zero_q;
  assign bus.resp_err     = err_q;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] grant_cnt_0_q, grant_cnt_0_d;
  logic [CNT_W-1:0] grant_cnt_1_q, grant_cnt_1_d;

  // Counters stick at all-ones rather than wrapping.
  always_comb begin
    grant_cnt_0_d = grant_cnt_0_q;
    grant_cnt_1_d = grant_cnt_1_q;
    if (grant_0 && (grant_cnt_0_q != {CNT_W{1'b1}}))
      grant_cnt_0_d = grant_cnt_0_q + CNT_W'(1);
    if (grant_1 && (grant_cnt_1_q != {CNT_W{1'b1}}))
      grant_cnt_1_d = grant_cnt_1_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_cnt_0_q <= '0;
      grant_cnt_1_q <= '0;
    end else begin
      grant_cnt_0_q <= grant_cnt_0_d;
      grant_cnt_1_q <= grant_cnt_1_d;
    end
  end

  assign grant_cnt_0 = grant_cnt_0_q;
  assign grant_cnt_1 = grant_cnt_1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: single requests, contention, backpressure, illegal ops,
// shift boundaries, reset mid-operation and (with ALU_ARB_STATS_EN) counter saturation.
module tb_alu_arbiter;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  alu_arbiter_if bus ();

`ifdef ALU_ARB_STATS_EN
  logic [1:0] grant_cnt_0;
  logic [1:0] grant_cnt_1;

  alu_arbiter #(.CNT_W(2)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus.slave),
    .grant_cnt_0 (grant_cnt_0),
    .grant_cnt_1 (grant_cnt_1)
  );
`else
  alu_arbiter dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on the falling edge; checks happen 1 time unit later.
  task automatic applyStimulus(
    input logic        v0, input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] op0,
    input logic        v1, input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] op1,
    input logic        rr0, input logic rr1
  );
    @(negedge clk);
    bus.req_valid_0  = v0;
    bus.req_a_0      = a0;
    bus.req_b_0      = b0;
    bus.req_op_0     = op0;
    bus.req_valid_1  = v1;
    bus.req_a_1      = a1;
    bus.req_b_1      = b1;
    bus.req_op_1     = op1;
    bus.resp_ready_0 = rr0;
    bus.resp_ready_1 = rr1;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkResp(input string tag, input logic v0, input logic v1,
                           input logic [31:0] data, input logic zero, input logic err);
    checkOutput({tag, " resp_valid_0"}, {31'd0, bus.resp_valid_0}, {31'd0, v0});
    checkOutput({tag, " resp_valid_1"}, {31'd0, bus.resp_valid_1}, {31'd0, v1});
    checkOutput({tag, " resp_data"},    bus.resp_data, data);
    checkOutput({tag, " resp_zero"},    {31'd0, bus.resp_zero}, {31'd0, zero});
    checkOutput({tag, " resp_err"},     {31'd0, bus.resp_err}, {31'd0, err});
  endtask

  task automatic checkReady(input string tag, input logic r0, input logic r1);
    checkOutput({tag, " req_ready_0"}, {31'd0, bus.req_ready_0}, {31'd0, r0});
    checkOutput({tag, " req_ready_1"}, {31'd0, bus.req_ready_1}, {31'd0, r1});
  endtask

`ifdef ALU_ARB_STATS_EN
  logic [1:0] exp_cnt [5];
`endif

  initial begin
    checks  = 0;
    errors  = 0;
    reset_n = 1'b0;
    bus.req_valid_0  = 1'b0;
    bus.req_a_0      = '0;
    bus.req_b_0      = '0;
    bus.req_op_0     = '0;
    bus.req_valid_1  = 1'b0;
    bus.req_a_1      = '0;
    bus.req_b_1      = '0;
    bus.req_op_1     = '0;
    bus.resp_ready_0 = 1'b1;
    bus.resp_ready_1 = 1'b1;

    #2;
    $display("[TB] reset state");
    checkResp("reset", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    checkReady("reset", 1'b0, 1'b0);

    @(negedge clk);
    reset_n = 1'b1;

    // Single requester on port 0: 5 - 3.
    $display("[TB] single requester");
    applyStimulus(1'b1, 32'd5, 32'd3, 4'd1, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
    checkReady("single0 accept", 1'b1, 1'b0);
    // Port 1 alone: 0xFFFFFFFF + 1 wraps to zero.
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'hFFFF_FFFF, 32'd1, 4'd0, 1'b1, 1'b1);
    checkResp("single0 result", 1'b1, 1'b0, 32'd2, 1'b0, 1'b0);
    checkReady("single1 accept", 1'b0, 1'b1);

    // Contention: both valid, pointer is back at port 0.
    $display("[TB] contention");
    applyStimulus(1'b1, 32'd7, 32'd7, 4'd1, 1'b1, 32'd1, 32'hFFFF_FFFF, 4'd7, 1'b1, 1'b1);
    checkResp("single1 result", 1'b0, 1'b1, 32'd0, 1'b1, 1'b0);
    checkReady("contend g1", 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd7, 32'd7, 4'd1, 1'b1, 32'd1, 32'hFFFF_FFFF, 4'd7, 1'b1, 1'b1);
    checkResp("contend r1", 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    checkReady("contend g2", 1'b0, 1'b1);
    applyStimulus(1'b1, 32'd7, 32'd7, 4'd1, 1'b1, 32'd1, 32'hFFFF_FFFF, 4'd7, 1'b1, 1'b1);
    checkResp("contend r2", 1'b0, 1'b1, 32'd0, 1'b1, 1'b0);
    checkReady("contend g3", 1'b1, 1'b0);

    // Backpressure: port 1 sra result held while resp_ready_1 is low.
    $display("[TB] backpressure");
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'h8000_0000, 32'd4, 4'd5, 1'b1, 1'b0);
    checkResp("contend r3", 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    checkReady("bp accept1", 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 32'd3, 32'd4, 4'd3, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
      checkResp("bp hold", 1'b0, 1'b1, 32'hF800_0000, 1'b0, 1'b0);
      checkReady("bp stall", 1'b0, 1'b0);
    end
    applyStimulus(1'b1, 32'd3, 32'd4, 4'd3, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
    checkResp("bp drain", 1'b0, 1'b1, 32'hF800_0000, 1'b0, 1'b0);
    checkReady("bp refill", 1'b1, 1'b0);

    // Illegal opcode, then legal ops including shift boundaries.
    $display("[TB] illegal opcode and shifts");
    applyStimulus(1'b1, 32'd123, 32'd1, 4'hA, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
    checkResp("bp queued result", 1'b1, 1'b0, 32'd7, 1'b0, 1'b0);
    checkReady("illegal accept", 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd1, 32'd1, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
    checkResp("illegal result", 1'b1, 1'b0, 32'd0, 1'b1, 1'b1);
    applyStimulus(1'b1, 32'd1, 32'd32, 4'd6, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
    checkResp("add after illegal", 1'b1, 1'b0, 32'd2, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h8000_0000, 32'd100, 4'd5, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
    checkResp("sll by 32", 1'b1, 1'b0, 32'd0, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'd1, 32'hFFFF_FFFF, 4'd8, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
    checkResp("sra by 100", 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
    checkResp("sltu", 1'b1, 1'b0, 32'd1, 1'b0, 1'b0);

    // Drain to EMPTY keeps the data; then port 1 fills the slot and reset hits.
    $display("[TB] reset mid-operation");
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'd2, 32'd2, 4'd0, 1'b1, 1'b0);
    checkResp("empty hold", 1'b0, 1'b0, 32'd1, 1'b0, 1'b0);
    checkReady("pre-reset accept", 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b0);
    checkResp("pre-reset result", 1'b0, 1'b1, 32'd4, 1'b0, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    checkResp("async reset", 1'b0, 1'b0, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 32'd10, 32'd5, 4'd0, 1'b1, 32'd9, 32'd3, 4'd1, 1'b1, 1'b1);
    checkReady("post-reset ptr", 1'b1, 1'b0);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 32'd9, 32'd3, 4'd1, 1'b1, 1'b1);
    checkResp("post-reset r0", 1'b1, 1'b0, 32'd15, 1'b0, 1'b0);
    checkReady("post-reset g1", 1'b0, 1'b1);
    applyStimulus(1'b0, 32'd0, 32'd0, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
    checkResp("post-reset r1", 1'b0, 1'b1, 32'd6, 1'b0, 1'b0);

`ifdef ALU_ARB_STATS_EN
    // Five port-0 grants against a 2-bit counter.
    $display("[TB] counter saturation");
    exp_cnt[0] = 2'd1;
    exp_cnt[1] = 2'd2;
    exp_cnt[2] = 2'd3;
    exp_cnt[3] = 2'd3;
    exp_cnt[4] = 2'd3;
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    checkOutput("cnt0 reset", {30'd0, grant_cnt_0}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    applyStimulus(1'b1, 32'd1, 32'd1, 4'hF, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      applyStimulus((i < 4), 32'd1, 32'd1, 4'd0, 1'b0, 32'd0, 32'd0, 4'd0, 1'b1, 1'b1);
      checkOutput("grant_cnt_0", {30'd0, grant_cnt_0}, {30'd0, exp_cnt[i]});
      checkOutput("grant_cnt_1", {30'd0, grant_cnt_1}, 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
